// File: rtl/aes_decrypt_ctrl_if.sv
// Ciphertext-in / plaintext-out handshake bundle for aes_decrypt_ctrl.
// slave  : the controller's view (accepts ciphertext, offers plaintext).
// master : the environment's view (offers ciphertext, accepts plaintext).
interface aes_decrypt_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption controller.
// Drives one shared external decrypt-round datapath over NR rounds, addresses
// an external round-key store (equivalent-inverse-cipher keys, combinational
// read), owns the 128-bit state register and both valid/ready handshakes.
// Optional feature: define AES_DEC_ABORT_EN to add an 'abort' input that
// drops an in-flight block (ROUND or DONE) back to IDLE without output.
module aes_decrypt_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef AES_DEC_ABORT_EN
  input  logic                  abort,
`endif
  aes_decrypt_ctrl_if.slave     bus,
  output logic [3:0]            rk_addr,
  input  logic [127:0]          rk_data,
  output logic [127:0]          rnd_in,
  output logic [127:0]          rnd_key,
  output logic                  rnd_final,
  input  logic [127:0]          rnd_out,
  output logic                  busy,
  output logic [3:0]            round
);

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   rk_addr_q, rk_addr_d;
  logic         rnd_final_q, rnd_final_d;
  logic         abort_req;

`ifdef AES_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Register FSM, data state, round counter and the key-store address.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= NR4;
      rk_addr_q   <= NR4;
      rnd_final_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      rk_addr_q   <= rk_addr_d;
      rnd_final_q <= rnd_final_d;
    end
  end

  // Next-state, datapath capture and round bookkeeping.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;

    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Initial whitening with round key NR, which rk_addr already selects.
          state_d = bus.in_data ^ rk_data;
          round_d = NR4 - 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd_out;
        if (round_q == 4'd0) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    // Abort wins over round completion and out_ready; state is left untouched
    // because it is never presented once the FSM is back in IDLE.
    if (abort_req && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      round_d = NR4;
      state_d = state_q;
    end
  end

  // Key address and final-round select are derived from the next FSM/round
  // values so that the registered copies line up with the cycle they serve.
  always_comb begin
    rk_addr_d   = NR4;
    rnd_final_d = 1'b0;
    unique case (fsm_d)
      IDLE:    rk_addr_d = NR4;
      ROUND: begin
        rk_addr_d   = round_d;
        rnd_final_d = (round_d == 4'd0);
      end
      DONE:    rk_addr_d = 4'd0;
      default: rk_addr_d = NR4;
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_data  = state_q;
  assign busy          = (fsm_q == ROUND);
  assign round         = round_q;
  assign rk_addr       = rk_addr_q;
  assign rnd_final     = rnd_final_q;
  assign rnd_in        = state_q;
  assign rnd_key       = rk_data;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Testbench for aes_decrypt_ctrl: supplies a behavioural AES round datapath
// and key store, and checks plaintexts against a standard inverse cipher.
module tb_aes_decrypt_ctrl;

  localparam int unsigned NR = 10;

  logic         clk;
  logic         reset;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic [127:0] rnd_out;
  logic         busy;
  logic [3:0]   round;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  aes_decrypt_ctrl_if bus ();

  aes_decrypt_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .bus       (bus),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .rnd_in    (rnd_in),
    .rnd_key   (rnd_key),
    .rnd_final (rnd_final),
    .rnd_out   (rnd_out),
    .busy      (busy),
    .round     (round)
  );

  int unsigned  n_checks;
  int unsigned  n_pass;
  int unsigned  cyc;
  int unsigned  last_acc;
  logic [127:0] rk_std    [0:10];
  logic [127:0] key_store [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Byte i of the block, byte 0 in the most significant position.
  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return 8'(s >> (8 * (15 - i)));
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], inv_sbox(gb(s, i))};
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o = {o[119:0], gb(s, (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4))};
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4 * c);
      a1 = gb(s, 4 * c + 1);
      a2 = gb(s, 4 * c + 2);
      a3 = gb(s, 4 * c + 3);
      o = {o[95:0],
           gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
           gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
           gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
           gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // Equivalent-inverse-cipher round, as the external datapath computes it.
  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin);
    logic [127:0] t;
    t = inv_shift_rows(inv_sub_bytes(s));
    if (!fin) t = inv_mix(t);
    return t ^ k;
  endfunction

  // Reference: textbook inverse cipher on the plain key schedule.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_std[10];
    for (int r = 9; r >= 1; r--) begin
      s = inv_sub_bytes(inv_shift_rows(s));
      s = inv_mix(s ^ rk_std[r]);
    end
    s = inv_sub_bytes(inv_shift_rows(s));
    return s ^ rk_std[0];
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_std[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int a = 0; a < 16; a++) key_store[a] = '0;
    key_store[0]  = rk_std[0];
    key_store[NR] = rk_std[10];
    for (int r = 1; r < 10; r++) key_store[r] = inv_mix(rk_std[r]);
  endtask

  assign rk_data = key_store[rk_addr];
  assign rnd_out = dp_round(rnd_in, rnd_key, rnd_final);

  // ---------------- checking / sequencing ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] ct);
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    last_acc     = cyc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] ct, input int unsigned hold, input bit chk_gap);
    logic [127:0] pt;
    pt = ref_decrypt(ct);
    check("idle_in_ready", 128'(bus.in_ready), 128'(1));
    check("idle_rk_addr", 128'(rk_addr), 128'(NR));
    bus.out_ready = (hold == 0);
    if (chk_gap) check("accept_spacing", 128'(cyc - last_acc), 128'(12));
    accept(ct);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      check("round_seq", 128'({busy, bus.in_ready, bus.out_valid, rnd_final, rk_addr}),
            128'({1'b1, 1'b0, 1'b0, (k == 9), 4'(9 - k)}));
      step();
    end
    check("latency", 128'(cyc - last_acc), 128'(11));
    check("plaintext", bus.out_data, pt);
    check("done_flags", 128'({bus.out_valid, bus.in_ready, busy, rk_addr}), 128'({3'b100, 4'd0}));
    for (int unsigned h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom);
      step();
      check("bp_data", bus.out_data, pt);
      check("bp_flags", 128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b100));
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("back_to_idle", 128'({bus.in_ready, bus.out_valid, busy, rk_addr}), 128'({3'b100, 4'(NR)}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    last_acc = 0;
    reset    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    step();
    step();
    check("rst_flags", 128'({bus.in_ready, bus.out_valid, busy, rnd_final}), 128'(4'b1000));
    check("rst_rk_round", 128'({rk_addr, round}), 128'({4'(NR), 4'(NR)}));
    check("rst_data", bus.out_data, '0);
    reset = 1'b0;
    step();

    // FIPS-197 C.1 known answer.
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0);
    check("fips_pt", bus.out_data, 128'h00112233445566778899aabbccddeeff);

    // Back-to-back with out_ready high throughout.
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);

    // Backpressure of five cycles.
    run_block({$urandom, $urandom, $urandom, $urandom}, 5, 1'b0);

    // Randomised keys, ciphertexts, gaps and backpressure.
    for (int n = 0; n < 6; n++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
        step();
        check("gap_in_ready", 128'(bus.in_ready), 128'(1));
      end
      run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(4, 0), 1'b0);
    end

    // Reset while at round index 5.
    accept({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 4; k++) step();
    check("pre_reset_idx", 128'(rk_addr), 128'(5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_flags", 128'({bus.out_valid, bus.in_ready, busy, rnd_final}), 128'(4'b0100));
    check("rst_mid_round", 128'({round, rk_addr}), 128'({4'(NR), 4'(NR)}));
    check("rst_mid_data", bus.out_data, '0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);

`ifdef AES_DEC_ABORT_EN
    // Abort at round index 3.
    accept({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 6; k++) step();
    check("pre_abort_idx", 128'(rk_addr), 128'(3));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_round", 128'({bus.in_ready, bus.out_valid, busy, round}), 128'({3'b100, 4'(NR)}));
    for (int k = 0; k < 12; k++) begin
      step();
      check("abort_no_valid", 128'(bus.out_valid), 128'(0));
    end
    // Abort together with out_ready in DONE.
    bus.out_ready = 1'b1;
    accept({$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 10; k++) step();
    check("abort_done_pre", 128'(bus.out_valid), 128'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done", 128'({bus.in_ready, bus.out_valid, round}), 128'({2'b10, 4'(NR)}));
    // Abort in IDLE does not block acceptance.
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    step();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_idle_accept", 128'({busy, rk_addr}), 128'({1'b1, 4'd9}));
    for (int k = 0; k < 10; k++) step();
    check("abort_idle_pt", bus.out_data, 128'h00112233445566778899aabbccddeeff);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
